// File: rtl/dt_pkg.sv
// dt_pkg: shared widths, arbiter state type and index helpers for the distance-transform slice
package dt_pkg;
    localparam int RES_ADDR_W = 14;
    localparam int RES_DATA_W = 8;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic logic [1:0] idx_wrap(input logic [1:0] i, input int n);
        return (int'(i) == n - 1) ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/dt_rr_pick.sv
// dt_rr_pick: combinational round-robin picker, first requester at or above ptr wins
module dt_rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       idx
);
    // scan offsets from farthest to nearest so the nearest active requester overwrites the rest
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && i == (int'(ptr) + k) % N_REQ) begin
                    gnt = '0;
                    gnt[i] = 1'b1;
                    idx = 2'(i);
                end
            end
        end
    end
endmodule

// File: rtl/res_mem_arbiter.sv
// res_mem_arbiter: round-robin arbiter with locked bursts for the shared result RAM port
module res_mem_arbiter
    import dt_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_LOCK = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             req_wr,
    input  logic [N_REQ-1:0]             req_lock,
    input  logic [N_REQ*RES_ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*RES_DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rvalid,
    output logic [RES_DATA_W-1:0]        rdata,
    output logic                         res_rd,
    output logic                         res_wr,
    output logic [RES_ADDR_W-1:0]        res_addr,
    output logic [RES_DATA_W-1:0]        res_do,
    input  logic [RES_DATA_W-1:0]        res_di,
    output logic [1:0]                   owner,
    output logic                         locked
);
    arb_state_t             state;
    logic [1:0]             rr_ptr;
    logic [1:0]             pick_idx;
    logic [1:0]             acc_idx;
    logic [1:0]             rd_idx;
    logic [6:0]             hold_cnt;
    logic [N_REQ-1:0]       pick_gnt;
    logic                   acc;
    logic                   acc_wr;
    logic                   acc_lock;
    logic [RES_ADDR_W-1:0]  acc_addr;
    logic [RES_DATA_W-1:0]  acc_data;

    dt_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );

    assign rdata  = res_di;
    assign locked = (state == LOCKED);

    // grant comes from the picker when idle, otherwise only the owner may be accepted
    always_comb begin
        gnt      = '0;
        acc_wr   = 1'b0;
        acc_lock = 1'b0;
        acc_addr = '0;
        acc_data = '0;
        acc_idx  = (state == IDLE) ? pick_idx : owner;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (state == IDLE) ? pick_gnt[i] : (2'(i) == owner) & req[i];
            if (2'(i) == acc_idx) begin
                acc_wr   = req_wr[i];
                acc_lock = req_lock[i];
                acc_addr = req_addr[i*RES_ADDR_W +: RES_ADDR_W];
                acc_data = req_wdata[i*RES_DATA_W +: RES_DATA_W];
            end
        end
        acc = |(req & gnt);
    end

    // register the memory command and return a read strobe to its issuer one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_rd   <= 1'b0;
            res_wr   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;
            rd_idx   <= '0;
            rvalid   <= '0;
        end else begin
            res_rd <= acc & ~acc_wr;
            res_wr <= acc & acc_wr;
            rd_idx <= acc_idx;
            rvalid <= res_rd ? N_REQ'(1) << rd_idx : '0;
            if (acc) begin
                res_addr <= acc_addr;
                res_do   <= acc_data;
            end
        end
    end

    // lock ownership, burst length limit and round-robin pointer advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
        end else if (acc) begin
            if (state == IDLE) begin
                if (acc_lock) begin
                    state    <= LOCKED;
                    owner    <= acc_idx;
                    hold_cnt <= 7'd1;
                end else begin
                    rr_ptr <= idx_wrap(acc_idx, N_REQ);
                end
            end else if (!acc_lock || hold_cnt == 7'(MAX_LOCK - 1)) begin
                state    <= IDLE;
                owner    <= '0;
                hold_cnt <= '0;
                rr_ptr   <= idx_wrap(owner, N_REQ);
            end else begin
                hold_cnt <= hold_cnt + 7'd1;
            end
        end
    end
endmodule

// File: tb/tb_res_mem_arbiter.sv
// tb_res_mem_arbiter: scoreboard bench with directed scenarios and randomized traffic against a reference model
module tb_res_mem_arbiter;
    localparam int N  = 3;
    localparam int ML = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req = '0, req_wr = '0, req_lock = '0;
    logic [N*14-1:0]  req_addr = '0;
    logic [N*8-1:0]   req_wdata = '0;
    logic [N-1:0]     gnt, rvalid;
    logic [7:0]       rdata, res_do;
    logic [7:0]       res_di = '0;
    logic             res_rd, res_wr, locked;
    logic [13:0]      res_addr;
    logic [1:0]       owner;

    res_mem_arbiter #(.N_REQ(N), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
        .res_do(res_do), .res_di(res_di), .owner(owner), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [13:0] addr; logic [7:0] data; } cmd_t;
    typedef struct { int idx; logic [7:0] data; } rd_t;
    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    cmd_t mc;
    rd_t  mr;

    logic [7:0] mem[16384];
    logic [7:0] ref_mem[16384];

    int checks = 0;
    int failures = 0;

    bit m_locked;
    int m_owner, m_hold, m_ptr;

    always @(posedge clk) begin
        if (res_wr) mem[res_addr] <= res_do;
        if (res_rd) res_di <= mem[res_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        if (m_locked) return r[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_hold   = 0;
        m_ptr    = 0;
        cmd_q.delete();
        rd_q.delete();
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                        input logic [N*14-1:0] a, input logic [N*8-1:0] d, output logic [N-1:0] gs);
        int g;
        cmd_t c;
        req = r; req_wr = w; req_lock = l; req_addr = a; req_wdata = d;
        #1;
        gs = gnt;
        g = model_pick(r);
        chk("gnt", gnt, g < 0 ? 0 : 1 << g);
        chk("locked", locked, m_locked);
        chk("owner", owner, m_locked ? m_owner : 0);
        if (g >= 0) begin
            c.wr = w[g];
            c.addr = a[g*14 +: 14];
            c.data = d[g*8 +: 8];
            cmd_q.push_back(c);
            if (c.wr) ref_mem[c.addr] = c.data;
            else rd_q.push_back('{g, ref_mem[c.addr]});
            if (m_locked) begin
                if (!l[g] || m_hold == ML - 1) begin
                    m_locked = 0;
                    m_ptr = (g + 1) % N;
                end else m_hold++;
            end else if (l[g]) begin
                m_locked = 1;
                m_owner = g;
                m_hold = 1;
            end else m_ptr = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_res_rd", res_rd, 0);
        chk("rst_res_wr", res_wr, 0);
        chk("rst_res_addr", res_addr, 0);
        chk("rst_res_do", res_do, 0);
        chk("rst_owner", owner, 0);
        chk("rst_locked", locked, 0);
    endtask

    task automatic apply_reset();
        req = '0; req_wr = '0; req_lock = '0;
        reset = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (res_rd || res_wr) begin
            if (cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
            else begin
                mc = cmd_q.pop_front();
                chk("cmd_wr", res_wr, mc.wr);
                chk("cmd_rd", res_rd, !mc.wr);
                chk("cmd_addr", res_addr, mc.addr);
                if (mc.wr) chk("cmd_data", res_do, mc.data);
            end
        end
        if (rvalid != 0) begin
            if (rd_q.size() == 0) chk("unexpected_rvalid", rvalid, 0);
            else begin
                mr = rd_q.pop_front();
                chk("rvalid", rvalid, 1 << mr.idx);
                chk("rdata", rdata, mr.data);
            end
        end
    end

    initial begin
        logic [N-1:0]    gs;
        logic [N*14-1:0] a;
        logic [N*8-1:0]  d;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[14'h0081] = 8'h07;
        ref_mem[14'h0081] = 8'h07;
        apply_reset();

        step(3'b001, 3'b000, 3'b000, {3{14'h0081}}, '0, gs);
        chk("single_gnt", gs, 3'b001);
        repeat (3) step('0, '0, '0, '0, '0, gs);

        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step(3'b111, 3'b000, 3'b000, {3{14'(k + 20)}}, '0, gs);
            chk("rr_order", gs, 1 << (k % 3));
        end

        for (int k = 0; k < 5; k++) begin
            step(3'b111, 3'b001, k < 4 ? 3'b001 : 3'b000, {3{14'(100 + k)}}, {3{8'(k + 1)}}, gs);
            chk("burst_gnt", gs, 3'b001);
        end
        step(3'b110, 3'b000, 3'b000, {3{14'd200}}, '0, gs);
        chk("burst_next_r1", gs, 3'b010);
        step(3'b100, 3'b000, 3'b000, {3{14'd201}}, '0, gs);
        chk("burst_next_r2", gs, 3'b100);

        for (int k = 0; k < ML; k++) begin
            step(k == 0 ? 3'b100 : 3'b101, 3'b000, 3'b100, {3{14'(300 + k)}}, '0, gs);
            chk("force_hold", gs, 3'b100);
        end
        chk("force_unlocked", locked, 0);
        step(3'b101, 3'b000, 3'b100, {3{14'd310}}, '0, gs);
        chk("force_r0", gs, 3'b001);

        step(3'b010, 3'b000, 3'b010, {3{14'd400}}, '0, gs);
        chk("idle_lock_gnt", gs, 3'b010);
        for (int k = 0; k < 3; k++) begin
            step(3'b001, 3'b000, 3'b000, {3{14'd401}}, '0, gs);
            chk("idle_gnt", gs, 0);
            chk("idle_locked", locked, 1);
            chk("idle_owner", owner, 1);
        end
        step(3'b011, 3'b000, 3'b000, {3{14'd402}}, '0, gs);
        chk("idle_resume", gs, 3'b010);
        repeat (3) step('0, '0, '0, '0, '0, gs);

        step(3'b010, 3'b000, 3'b000, {3{14'd5}}, '0, gs);
        chk("midread_res_rd", res_rd, 1);
        req = '0;
        reset = 1'b0;
        #1;
        chk("midread_rd_drop", res_rd, 0);
        check_reset_values();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step('0, '0, '0, '0, '0, gs);
            chk("midread_no_rvalid", rvalid, 0);
        end

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                a[i*14 +: 14] = 14'($urandom_range(0, 15));
                d[i*8 +: 8] = 8'($urandom);
            end
            step(N'($urandom), N'($urandom), N'($urandom) & N'($urandom), a, d, gs);
        end
        repeat (4) step('0, '0, '0, '0, '0, gs);

        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/res_mem_arbiter.md
# res_mem_arbiter

Arbiter for the single-port 16384x8 result memory (res RAM) shared by the distance-transform engine and other on-chip requesters (e.g. host readback, init-fill). It grants one memory access per cycle using round-robin priority. It supports locked bursts, so a forward or backward raster pass keeps the port without interleaving. It registers the memory command and routes read data back to the issuing requester.

## Interface
Parameters:
- N_REQ, 3: number of requesters (2..4).
- MAX_LOCK, 64: maximum consecutive accepted cycles a locked owner may hold the port.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- req  in  N_REQ  per-requester access request.
- req_wr  in  N_REQ  1 = write, 0 = read.
- req_lock  in  N_REQ  keep ownership after this access.
- req_addr  in  N_REQ*14  flattened addresses, requester i at [14i+13:14i].
- req_wdata  in  N_REQ*8  flattened write data.
- gnt  out  N_REQ  combinational accept; access taken on an edge where req[i]&gnt[i].
- rvalid  out  N_REQ  registered read-data-valid strobe.
- rdata  out  8  read data, equals res_di.
- res_rd  out  1  registered memory read strobe.
- res_wr  out  1  registered memory write strobe.
- res_addr  out  14  registered memory address.
- res_do  out  8  registered memory write data.
- res_di  in  8  memory read data, valid the cycle after res_rd.
- owner  out  2  index of current lock owner, 0 when unlocked.
- locked  out  1  high in LOCKED state.

## Operation
- States: IDLE and LOCKED.
- IDLE:
  - gnt is one-hot to the first requester with req=1, searching upward from rr_ptr and wrapping at N_REQ-1 to 0.
  - gnt is all zero if there is no request.
  - On accept with req_lock=1: go to LOCKED, owner=i, hold_cnt=1.
  - On accept with req_lock=0: stay in IDLE.
- LOCKED:
  - gnt[owner]=req[owner]; all other gnt bits are 0.
  - On accept with req_lock=0: go to IDLE.
  - On accept with hold_cnt==MAX_LOCK-1: go to IDLE regardless of req_lock (forced release).
  - Other accepts: hold_cnt+1.
  - Owner idle (req=0) does not release the lock and does not count.
- rr_ptr:
  - On every return to IDLE, and on every unlocked accept, rr_ptr = (granted index + 1) mod N_REQ.
  - Reset value 0.
- Accepted access:
  - On the accept edge, register res_addr, res_do and a one-hot res_rd/res_wr.
  - res_rd/res_wr are 0 in cycles with no accept.
  - res_addr/res_do hold their last value when there is no accept.
- Read return:
  - A read accepted at edge E drives res_rd during E..E+1.
  - rvalid[i] is registered high during E+1..E+2.
  - rdata = res_di, passed through combinationally.
- Writes never raise rvalid.
- Write-then-read to the same address on back-to-back cycles returns the new data; this is memory behaviour, and the arbiter adds no hazard logic.

## Timing
- Reset values: gnt=0, rvalid=0, res_rd=0, res_wr=0, res_addr=0, res_do=0, owner=0, locked=0, rr_ptr=0, hold_cnt=0, state IDLE.
- Throughput: one access per cycle.
- Read latency: 2 edges from accept to the rvalid-sampling edge.
- Reset mid-operation:
  - Any pending rvalid is dropped.
  - The lock is cleared.
  - The memory strobe deasserts immediately (asynchronous).
- Requester changing addr/wr/data while req=1 and gnt=0 is legal; the values sampled at the accept edge are used.
- req_lock sampled from a non-owner in LOCKED is ignored.
- hold_cnt: 7 bits wide, saturating check only.

## Structure
- Shared package dt_pkg:
  - RES_ADDR_W=14, RES_DATA_W=8.
  - typedef arb_state_t {IDLE, LOCKED}.
  - Function idx_wrap for the modulo-N increment.
- One sub-module, dt_rr_pick: combinational round-robin picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot gnt and binary index.
  - Reused by future host arbiters.

## Test plan
- Reset mid-read: accept read r1 @ addr 5, assert reset at E+1 -> rvalid stays 0, res_rd=0, all outputs at reset values.
- Single read: r0 reads addr 0x0081 with memory holding 0x07 -> gnt[0] same cycle, res_rd=1 addr 0x0081 next cycle, rvalid[0]=1 with rdata=0x07 one cycle later.
- Round robin: all 3 requesters issue continuous unlocked reads from reset -> grant order 0,1,2,0,1,2; no requester waits more than 2 cycles.
- Locked burst: r0 locks 5 writes (addr 100..104, data 1..5) while r1/r2 request -> gnt only to r0 for 5 cycles, then r1 granted, then r2.
- Forced release: MAX_LOCK=4, r2 holds req_lock=1 continuously with r0 requesting -> r2 receives exactly 4 accepts, then r0 granted, locked=0.
- Owner idle: r1 locked, deasserts req for 3 cycles while r0 requests -> gnt[0] stays 0, locked=1, owner=1; r1 resumes and is accepted.
